// File: rtl/tap_apb_master_pkg.sv
// Shared widths, completion codes and FSM encoding for the TAP-to-APB requester.
package tap_apb_master_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ERR_WIDTH  = 2;

   typedef enum logic [ERR_WIDTH-1:0] {
      FAIL_DONE         = 2'b00,
      FAIL_INVALID_ADDR = 2'b01,
      FAIL_SLV_ERR      = 2'b10,
      FAIL_TIMEOUT      = 2'b11
   } fail_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_REJECT = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   // One extra bit so base+size can run past the top of the address space
   // without wrapping back onto low addresses.
   function automatic logic addr_in_window(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [ADDR_WIDTH-1:0] base,
                                           input logic [ADDR_WIDTH-1:0] size);
      logic [ADDR_WIDTH:0] a;
      logic [ADDR_WIDTH:0] lo;
      logic [ADDR_WIDTH:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/tap_apb_master_if.sv
// TAP request/response handshake plus APB3 bus, bundled for the requester and its peers.
interface tap_apb_master_if;
   import tap_apb_master_pkg::*;

   logic                  TRANSFER_tap_apb;
   logic                  RorW_tap_apb;
   logic [ADDR_WIDTH-1:0] ADDR_tap_apb;
   logic [DATA_WIDTH-1:0] DATA_tap_apb;
   logic                  DONE_apb_tap;
   logic [ERR_WIDTH-1:0]  FAIL_apb_tap;
   logic [DATA_WIDTH-1:0] DATA_apb_tap;

   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic [DATA_WIDTH-1:0] PRDATA;

   modport master (
      input  TRANSFER_tap_apb, RorW_tap_apb, ADDR_tap_apb, DATA_tap_apb,
      output DONE_apb_tap, FAIL_apb_tap, DATA_apb_tap,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PSLVERR, PRDATA
   );

   modport slave (
      output TRANSFER_tap_apb, RorW_tap_apb, ADDR_tap_apb, DATA_tap_apb,
      input  DONE_apb_tap, FAIL_apb_tap, DATA_apb_tap,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PSLVERR, PRDATA
   );

endinterface

// File: rtl/tap_apb_master_wdog.sv
// ACCESS-phase watchdog: down-counter loaded on clr, expired at terminal count zero.
module tap_apb_master_wdog #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic TCK,
   input  logic TRST,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= LOAD;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/tap_apb_master.sv
// Executes one TAP-issued APB3 read/write at a time and reports DONE/FAIL/DATA back to the TAP.
// Optional ACCESS timeout enabled by defining TAP_APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for TRANSFER_tap_apb strobe
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, waiting for PREADY (or timeout)
// REJECT | address outside window, no APB cycle issued
// RESP   | DONE_apb_tap high for this one cycle
module tap_apb_master
   import tap_apb_master_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE = 32'h0001_0000
`ifdef TAP_APB_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 256
`endif
) (
   input logic              TCK,
   input logic              TRST,
   tap_apb_master_if.master bus
);

   state_e                state_q,   state_d;
   logic                  psel_q,    psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q,  pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
   logic                  done_q,    done_d;
   fail_e                 fail_q,    fail_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   logic                  timed_out;

`ifdef TAP_APB_TIMEOUT_EN
   logic wdog_expired;

   tap_apb_master_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .TCK     (TCK),
      .TRST    (TRST),
      .clr     (state_q == ST_SETUP),
      .en      ((state_q == ST_ACCESS) && !bus.PREADY),
      .expired (wdog_expired)
   );

   assign timed_out = wdog_expired;
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         state_q   <= ST_IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         done_q    <= 1'b0;
         fail_q    <= FAIL_DONE;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      done_d    = 1'b0;
      fail_d    = fail_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.TRANSFER_tap_apb) begin
               if (addr_in_window(bus.ADDR_tap_apb, ADDR_BASE, ADDR_SIZE)) begin
                  paddr_d  = bus.ADDR_tap_apb;
                  pwrite_d = bus.RorW_tap_apb;
                  pwdata_d = bus.DATA_tap_apb;
                  psel_d   = 1'b1;
                  state_d  = ST_SETUP;
               end else begin
                  state_d  = ST_REJECT;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY on the terminal watchdog cycle still completes normally
            if (bus.PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               fail_d    = bus.PSLVERR ? FAIL_SLV_ERR : FAIL_DONE;
               rdata_d   = (bus.PSLVERR || pwrite_q) ? '0 : bus.PRDATA;
               state_d   = ST_RESP;
            end else if (timed_out) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               fail_d    = FAIL_TIMEOUT;
               rdata_d   = '0;
               state_d   = ST_RESP;
            end
         end
         ST_REJECT: begin
            done_d  = 1'b1;
            fail_d  = FAIL_INVALID_ADDR;
            rdata_d = '0;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.PSEL         = psel_q;
   assign bus.PENABLE      = penable_q;
   assign bus.PWRITE       = pwrite_q;
   assign bus.PADDR        = paddr_q;
   assign bus.PWDATA       = pwdata_q;
   assign bus.DONE_apb_tap = done_q;
   assign bus.FAIL_apb_tap = fail_q;
   assign bus.DATA_apb_tap = rdata_q;

endmodule

// File: tb/tb_tap_apb_master.sv
// Randomized transaction bench for tap_apb_master against a transaction-level reference model.
module tb_tap_apb_master;
   import tap_apb_master_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] SIZE = 32'h0001_0000;
`ifdef TAP_APB_TIMEOUT_EN
   localparam int TC = 8;
`endif

   logic TCK = 1'b0;
   logic TRST;
   int   total = 0;
   int   bad   = 0;

   tap_apb_master_if bus();

`ifdef TAP_APB_TIMEOUT_EN
   tap_apb_master #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE), .TIMEOUT_CYC(TC)) dut (
      .TCK(TCK), .TRST(TRST), .bus(bus));
`else
   tap_apb_master #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
      .TCK(TCK), .TRST(TRST), .bus(bus));
`endif

   always #5 TCK = ~TCK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la >= longint'(BASE)) && (la < longint'(BASE) + longint'(SIZE));
   endfunction

   task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic slverr, input logic [31:0] prdata,
                          input bit extra);
      bit          valid;
      bit          tout;
      int          exp_acc;
      int          exp_lat;
      logic [1:0]  exp_fail;
      logic [31:0] exp_data;
      int          acc;
      int          ndone;
      int          done_at;
      bit          psel0;
      bit          pen0;
      bit          apb_ok;
      logic [1:0]  fail_at;
      logic [31:0] data_at;

      valid = in_window(addr);
      tout  = 1'b0;
`ifdef TAP_APB_TIMEOUT_EN
      if (valid && waits >= TC) tout = 1'b1;
`endif
      if (!valid) begin
         exp_acc = 0; exp_fail = 2'b01; exp_data = '0;
      end else if (tout) begin
`ifdef TAP_APB_TIMEOUT_EN
         exp_acc = TC;
`else
         exp_acc = 0;
`endif
         exp_fail = 2'b11; exp_data = '0;
      end else begin
         exp_acc  = waits + 1;
         exp_fail = slverr ? 2'b10 : 2'b00;
         exp_data = (slverr || rw) ? 32'h0 : prdata;
      end
      exp_lat = 1 + exp_acc;

      acc = 0; ndone = 0; done_at = -1; psel0 = 1'b0; pen0 = 1'b0; apb_ok = 1'b1;
      fail_at = '0; data_at = '0;

      @(negedge TCK);
      bus.TRANSFER_tap_apb = 1'b1;
      bus.RorW_tap_apb     = rw;
      bus.ADDR_tap_apb     = addr;
      bus.DATA_tap_apb     = wdata;
      @(negedge TCK);
      bus.TRANSFER_tap_apb = 1'b0;
      bus.RorW_tap_apb     = 1'($urandom);
      bus.ADDR_tap_apb     = $urandom;
      bus.DATA_tap_apb     = $urandom;

      for (int i = 0; i < exp_lat + 4; i++) begin
         if (i == 0) begin
            psel0 = bus.PSEL;
            pen0  = bus.PENABLE;
         end
         if (bus.PSEL) begin
            if (bus.PADDR !== addr || bus.PWRITE !== rw || bus.PWDATA !== wdata) apb_ok = 1'b0;
         end
         if (bus.PENABLE && !bus.PSEL) apb_ok = 1'b0;
         if (bus.DONE_apb_tap) begin
            ndone++;
            if (done_at < 0) begin
               done_at = i;
               fail_at = bus.FAIL_apb_tap;
               data_at = bus.DATA_apb_tap;
            end
         end
         if (bus.PSEL && bus.PENABLE) begin
            acc++;
            bus.PREADY  = (acc == waits + 1);
            bus.PSLVERR = (acc == waits + 1) ? slverr : 1'($urandom);
            bus.PRDATA  = (acc == waits + 1) ? prdata : $urandom;
         end else begin
            bus.PREADY  = 1'($urandom);
            bus.PSLVERR = 1'($urandom);
            bus.PRDATA  = $urandom;
         end
         if (extra && i == 1) begin
            bus.TRANSFER_tap_apb = 1'b1;
            bus.ADDR_tap_apb     = {16'h0, 16'($urandom)};
         end else begin
            bus.TRANSFER_tap_apb = 1'b0;
         end
         @(negedge TCK);
      end
      bus.PREADY = 1'b0;

      check("psel_setup",  psel0,   valid);
      check("pen_setup",   pen0,    1'b0);
      check("access_cyc",  acc,     exp_acc);
      check("apb_stable",  apb_ok,  1'b1);
      check("done_count",  ndone,   1);
      check("done_lat",    done_at, exp_lat);
      check("fail_code",   fail_at, exp_fail);
      check("rd_data",     data_at, exp_data);
      check("psel_end",    {bus.PSEL, bus.PENABLE}, 2'b00);
      check("fail_hold",   bus.FAIL_apb_tap, exp_fail);
      check("data_hold",   bus.DATA_apb_tap, exp_data);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"},    {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.DONE_apb_tap}, 4'b0000);
      check({tag, "_paddr"},  bus.PADDR,        32'h0);
      check({tag, "_pwdata"}, bus.PWDATA,       32'h0);
      check({tag, "_fail"},   bus.FAIL_apb_tap, 2'b00);
      check({tag, "_data"},   bus.DATA_apb_tap, 32'h0);
   endtask

   task automatic reset_mid_access();
      int ndone;
      ndone = 0;
      @(negedge TCK);
      bus.TRANSFER_tap_apb = 1'b1;
      bus.RorW_tap_apb     = 1'b1;
      bus.ADDR_tap_apb     = 32'h0000_0040;
      bus.DATA_tap_apb     = 32'hDEAD_BEEF;
      bus.PREADY           = 1'b0;
      @(negedge TCK);
      bus.TRANSFER_tap_apb = 1'b0;
      @(negedge TCK);
      check("mid_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      #2 TRST = 1'b1;
      #1 check_all_zero("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(negedge TCK);
         if (bus.DONE_apb_tap) ndone++;
      end
      TRST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge TCK);
         if (bus.DONE_apb_tap || bus.PSEL) ndone++;
      end
      check("rst_no_done", ndone, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          w;
      int          sel;
      TRST = 1'b1;
      bus.TRANSFER_tap_apb = 1'b0;
      bus.RorW_tap_apb     = 1'b0;
      bus.ADDR_tap_apb     = '0;
      bus.DATA_tap_apb     = '0;
      bus.PREADY           = 1'b0;
      bus.PSLVERR          = 1'b0;
      bus.PRDATA           = '0;
      #1 check_all_zero("rst_init");
      repeat (2) @(negedge TCK);
      TRST = 1'b0;
      @(negedge TCK);

      run_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 1'b0, 32'h0, 1'b0);
      run_txn(1'b0, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h1234_5678, 1'b0);
      run_txn(1'b0, 32'h0002_0000, 32'h0,         0, 1'b0, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0030, 32'h0F0F_F0F0, 2, 1'b1, 32'h5555_AAAA, 1'b1);
      run_txn(1'b0, 32'h0000_FFFF, 32'h0,         1, 1'b0, 32'hCAFE_0001, 1'b0);
      run_txn(1'b0, 32'h0001_0000, 32'h0,         0, 1'b0, 32'hCAFE_0002, 1'b1);
`ifdef TAP_APB_TIMEOUT_EN
      run_txn(1'b0, 32'h0000_0050, 32'h0,        20, 1'b0, 32'h7777_7777, 1'b0);
      run_txn(1'b0, 32'h0000_0054, 32'h0,    TC - 1, 1'b0, 32'h8888_8888, 1'b0);
`endif

      run_txn(1'b0, 32'h0000_0100, 32'h0,         0, 1'b0, 32'h9ABC_DEF0, 1'b0);
      reset_mid_access();
      run_txn(1'b0, 32'h0000_0200, 32'h0,         1, 1'b0, 32'h0BAD_F00D, 1'b0);

      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0:       a = 32'h0000_FFFF;
            1:       a = 32'h0001_0000;
            2:       a = $urandom;
            3:       a = 32'hFFFF_FFFF;
            4:       a = 32'h0000_0000;
            default: a = {16'h0, 16'($urandom)};
         endcase
         w = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
         run_txn(1'($urandom), a, $urandom, w, ($urandom_range(0, 3) == 0), $urandom,
                 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
